// File: rtl/clock_divider_scheduler_pkg.sv
// rtl/clock_divider_scheduler_pkg.sv - shared constants and helpers for the divider scheduler
package clock_divider_scheduler_pkg;

  localparam int CDS_WIDTH       = 32;
  localparam int CDS_DEFAULT_DIV = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Index width for n items, never below one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/clock_divider_scheduler_rr_picker.sv
// rtl/clock_divider_scheduler_rr_picker.sv - combinational round-robin pick after last_grant
module clock_divider_scheduler_rr_picker
  import clock_divider_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last_grant,
  output logic               grant_valid,
  output logic [IDXW-1:0]    grant_idx
);

  int idx;

  // Scan farthest-first so the nearest requester after last_grant is written last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/clock_divider_scheduler.sv
// rtl/clock_divider_scheduler.sv - shared programmable clock divider with glitch-free rate handover
module clock_divider_scheduler
  import clock_divider_scheduler_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  WIDTH       = CDS_WIDTH,
  parameter int  DEFAULT_DIV = CDS_DEFAULT_DIV,
  localparam int IDXW        = clog2(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_div,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic                     busy,
  output logic [WIDTH-1:0]         active_div,
  output logic [IDXW-1:0]          active_owner,
  output logic                     clk_out,
  output logic                     tick
);

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   counter_q, counter_d;
  logic [WIDTH-1:0]   active_div_q, active_div_d;
  logic [WIDTH-1:0]   pend_div_q, pend_div_d;
  logic [IDXW-1:0]    pend_idx_q, pend_idx_d;
  logic [IDXW-1:0]    last_grant_q, last_grant_d;
  logic [IDXW-1:0]    active_owner_q, active_owner_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic               clk_out_q, clk_out_d;
  logic               tick_q, tick_d;

  logic               grant_valid;
  logic [IDXW-1:0]    grant_idx;
  logic [WIDTH-1:0]   div_last;
  logic               at_terminal;
  logic               apply_point;

  clock_divider_scheduler_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_rr_picker (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign div_last    = active_div_q - WIDTH'(1);
  assign at_terminal = (active_div_q != '0) && (counter_q == div_last);
  // Only the end of a high half (or a halted divider) can take a new rate without a runt.
  assign apply_point = (active_div_q == '0) || (at_terminal && clk_out_q);

  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    active_div_d   = active_div_q;
    pend_div_d     = pend_div_q;
    pend_idx_d     = pend_idx_q;
    last_grant_d   = last_grant_q;
    active_owner_d = active_owner_q;
    req_ack_d      = '0;
    clk_out_d      = clk_out_q;
    tick_d         = 1'b0;

    if (active_div_q == '0) begin
      counter_d = '0;
      clk_out_d = 1'b0;
    end else if (at_terminal) begin
      counter_d = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = 1'b1;
    end else begin
      counter_d = counter_q + WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          pend_idx_d = grant_idx;
          pend_div_d = req_div[int'(grant_idx)*WIDTH +: WIDTH];
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req_valid[pend_idx_q]) begin
          state_d = ST_IDLE;
        end else if (pend_div_q == active_div_q) begin
          req_ack_d[pend_idx_q] = 1'b1;
          last_grant_d          = pend_idx_q;
          active_owner_d        = pend_idx_q;
          state_d               = ST_IDLE;
        end else if (apply_point) begin
          active_div_d          = pend_div_q;
          counter_d             = '0;
          clk_out_d             = 1'b0;
          tick_d                = clk_out_q;
          req_ack_d[pend_idx_q] = 1'b1;
          last_grant_d          = pend_idx_q;
          active_owner_d        = pend_idx_q;
          state_d               = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      counter_q      <= '0;
      active_div_q   <= WIDTH'(DEFAULT_DIV);
      pend_div_q     <= '0;
      pend_idx_q     <= '0;
      last_grant_q   <= IDXW'(NUM_REQ - 1);
      active_owner_q <= '0;
      req_ack_q      <= '0;
      clk_out_q      <= 1'b0;
      tick_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      active_div_q   <= active_div_d;
      pend_div_q     <= pend_div_d;
      pend_idx_q     <= pend_idx_d;
      last_grant_q   <= last_grant_d;
      active_owner_q <= active_owner_d;
      req_ack_q      <= req_ack_d;
      clk_out_q      <= clk_out_d;
      tick_q         <= tick_d;
    end
  end

  assign req_ack      = req_ack_q;
  assign busy         = (state_q == ST_WAIT);
  assign active_div   = active_div_q;
  assign active_owner = active_owner_q;
  assign clk_out      = clk_out_q;
  assign tick         = tick_q;

endmodule

// File: tb/tb_clock_divider_scheduler.sv
// tb/tb_clock_divider_scheduler.sv - scoreboard bench for the divider scheduler
module tb_clock_divider_scheduler;

  localparam int NR = 4;
  localparam int W  = 32;

  typedef struct {
    int          idx;
    logic [31:0] div;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*W-1:0] req_div = '0;
  logic [NR-1:0] req_ack;
  logic          busy;
  logic [W-1:0]  active_div;
  logic [1:0]    active_owner;
  logic          clk_out;
  logic          tick;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  logic        prev_clk = 1'b0;
  int          run = 0;
  logic [31:0] run_div = '0;
  logic        skip_half = 1'b1;

  clock_divider_scheduler #(
    .NUM_REQ     (NR),
    .WIDTH       (W),
    .DEFAULT_DIV (4)
  ) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_div      (req_div),
    .req_ack      (req_ack),
    .busy         (busy),
    .active_div   (active_div),
    .active_owner (active_owner),
    .clk_out      (clk_out),
    .tick         (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: half-period lengths, tick/toggle agreement, and scoreboard of acks.
  always @(negedge clk_in) begin
    if (!reset_n) begin
      prev_clk  = 1'b0;
      run       = 0;
      run_div   = active_div;
      skip_half = 1'b1;
    end else begin
      check_val("tick_vs_toggle", tick, clk_out != prev_clk);
      if (clk_out != prev_clk) begin
        if (!skip_half) check_val("half_period", run, run_div);
        run       = 1;
        run_div   = active_div;
        skip_half = (active_div == 0);
      end else begin
        run++;
        if (active_div !== run_div) begin
          if (!skip_half) check_val("apply_at_fall_only", active_div, run_div);
          skip_half = 1'b1;
          run_div   = active_div;
        end
      end
      prev_clk = clk_out;
      if (req_ack != 0) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_ack", req_ack, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_val("ack_idx", req_ack, 4'(1 << e.idx));
          check_val("ack_active_div", active_div, e.div);
          check_val("ack_owner", active_owner, e.idx);
          check_val("busy_at_ack", busy, 0);
        end
      end
    end
  end

  task automatic raise(input int idx, input logic [31:0] div, input bit expect_ack);
    exp_t e;
    req_div[idx*W +: W] = div;
    req_valid[idx] = 1'b1;
    if (expect_ack) begin
      e.idx = idx;
      e.div = div;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_acks(input logic [NR-1:0] mask, input int budget);
    logic [NR-1:0] seen;
    int n;
    seen = '0;
    n = 0;
    while (seen != mask && n < budget) begin
      @(posedge clk_in); #1;
      n++;
      seen = seen | (req_ack & mask);
      req_valid = req_valid & ~req_ack;
    end
    check_val("ack_within_budget", seen, mask);
    req_valid = req_valid & ~mask;
  endtask

  task automatic req_fixed(input int idx, input logic [31:0] div);
    raise(idx, div, 1'b1);
    @(posedge clk_in); #1;
    check_val("busy_in_wait", busy, 1);
    @(posedge clk_in); #1;
    check_val("ack_one_after_wait", req_ack[idx], 1);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    do begin
      @(posedge clk_in); #1;
      n++;
    end while (!(clk_out && tick) && n < 40);
    check_val("rise_seen", clk_out && tick, 1);
  endtask

  initial begin
    int ticks;
    int n;
    int hits;

    repeat (3) @(posedge clk_in);
    #1;
    check_val("rst_clk_out", clk_out, 0);
    check_val("rst_tick", tick, 0);
    check_val("rst_ack", req_ack, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_active_div", active_div, 4);
    check_val("rst_owner", active_owner, 0);
    reset_n = 1'b1;

    // Free-running at the default rate.
    ticks = 0;
    repeat (40) begin
      @(posedge clk_in); #1;
      ticks += int'(tick);
    end
    check_val("default_tick_count", ticks, 10);
    check_val("idle_busy", busy, 0);

    // Slow-to-fast handover waits for the falling edge.
    raise(0, 2, 1'b1);
    @(posedge clk_in); #1;
    check_val("busy_after_req", busy, 1);
    wait_acks(4'b0001, 9);
    repeat (8) @(posedge clk_in);
    #1;
    check_val("div2_active", active_div, 2);

    // Two simultaneous requests, twice, to exercise round-robin restart.
    raise(1, 5, 1'b1);
    raise(2, 3, 1'b1);
    wait_acks(4'b0110, 40);
    raise(1, 2, 1'b1);
    raise(2, 6, 1'b1);
    wait_acks(4'b0110, 40);
    check_val("rr_owner", active_owner, 2);

    // Halt, then restart from halt with immediate apply.
    raise(0, 0, 1'b1);
    wait_acks(4'b0001, 13);
    hits = 0;
    repeat (10) begin
      @(posedge clk_in); #1;
      hits += int'(clk_out) + int'(tick);
    end
    check_val("halt_held_low", hits, 0);
    req_fixed(0, 3);
    wait_rise(n);
    check_val("first_low_half_after_halt", n, 3);

    // Withdraw during WAIT just as the apply point arrives.
    wait_rise(n);
    raise(3, 7, 1'b0);
    @(posedge clk_in); #1;
    check_val("withdraw_wait", busy, 1);
    @(posedge clk_in); #1;
    check_val("withdraw_still_wait", busy, 1);
    req_valid[3] = 1'b0;
    @(posedge clk_in); #1;
    check_val("withdraw_idle", busy, 0);
    check_val("withdraw_div", active_div, 3);
    check_val("withdraw_owner", active_owner, 0);
    repeat (12) @(posedge clk_in);
    #1;

    // Equal divider is acked without touching phase.
    req_fixed(2, 3);
    check_val("equal_owner", active_owner, 2);
    repeat (8) @(posedge clk_in);
    #1;

    // Reset pulse mid-WAIT.
    raise(1, 9, 1'b0);
    @(posedge clk_in); #1;
    check_val("busy_before_reset", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_clk_out", clk_out, 0);
    check_val("midrst_tick", tick, 0);
    check_val("midrst_ack", req_ack, 0);
    check_val("midrst_active_div", active_div, 4);
    check_val("midrst_owner", active_owner, 0);
    req_valid = '0;
    @(posedge clk_in); #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk_in);
    #1;

    check_val("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
